exit_status_monitor: RTL

EXIT_STATUS_MONITOR -- requirements
Module: exit_status_monitor

---
 rtl/exit_mon_pkg.sv | 19 +
 rtl/exit_mon_timer.sv | 47 ++++
 rtl/exit_status_monitor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/exit_mon_pkg.sv
// Shared FSM state encoding and exit-code constants for the exit-status monitor.
// Also holds the channel-index width helper used by the port lists.
package exit_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int EXIT_SUCCESS = 0;
  localparam int EXIT_FAIL    = 1;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exit_mon_timer.sv
// Saturating run-cycle counter with a budget latched at clear; expire_o flags the last budgeted cycle.
// Counter value is exported only when EXIT_MON_CYCLE_STAMP_EN is defined.
module exit_mon_timer #(
  parameter int TMO_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [TMO_W-1:0] budget_i,
`ifdef EXIT_MON_CYCLE_STAMP_EN
  output logic [TMO_W-1:0] cnt_o,
`endif
  output logic             expire_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] budget_q, budget_d;

  always_comb begin
    cnt_d    = cnt_q;
    budget_d = budget_q;
    if (clear_i) begin
      cnt_d    = '0;
      budget_d = budget_i;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      budget_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      budget_q <= budget_d;
    end
  end

`ifdef EXIT_MON_CYCLE_STAMP_EN
  assign cnt_o = cnt_q;
`endif
  // A zero budget never expires, so the timeout is disabled.
  assign expire_o = en_i && (budget_q != '0) && (cnt_q == budget_q - TMO_W'(1));

endmodule

// File: rtl/exit_status_monitor.sv
// Collects one exit code per channel, reports done/pass/timeout; status is registered (1-cycle after the write).
// wr_ready_o is high only in RUN; EXIT_MON_CYCLE_STAMP_EN adds per-channel cycle stamps on rd_stamp_o.
module exit_status_monitor
  import exit_mon_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CODE_W = 32,
  parameter int TMO_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [TMO_W-1:0]          timeout_cyc_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [ch_width(N_CH)-1:0] wr_ch_i,
  input  logic [CODE_W-1:0]         wr_code_i,
  output logic                      done_o,
  output logic                      pass_o,
  output logic                      timeout_o,
  output logic [N_CH-1:0]           done_mask_o,
  output logic [N_CH-1:0]           fail_mask_o,
  input  logic [ch_width(N_CH)-1:0] rd_ch_i,
`ifdef EXIT_MON_CYCLE_STAMP_EN
  output logic [TMO_W-1:0]          rd_stamp_o,
`endif
  output logic [CODE_W-1:0]         rd_code_o
);

  localparam int CH_W = ch_width(N_CH);

  state_e            state_q, state_d;
  logic [N_CH-1:0]   done_mask_q, done_mask_d;
  logic [N_CH-1:0]   fail_mask_q, fail_mask_d;
  logic [CODE_W-1:0] code_q [N_CH];
  logic [CODE_W-1:0] code_d [N_CH];
`ifdef EXIT_MON_CYCLE_STAMP_EN
  logic [TMO_W-1:0]  stamp_q [N_CH];
  logic [TMO_W-1:0]  stamp_d [N_CH];
  logic [TMO_W-1:0]  cnt;
`endif
  logic run, wr_fire, expire;

  assign run     = (state_q == ST_RUN);
  // A restart in the same cycle as a write discards the write.
  assign wr_fire = wr_valid_i && run && !start_i;

  exit_mon_timer #(.TMO_W(TMO_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (start_i),
    .en_i     (run && !start_i),
    .budget_i (timeout_cyc_i),
`ifdef EXIT_MON_CYCLE_STAMP_EN
    .cnt_o    (cnt),
`endif
    .expire_o (expire)
  );

  always_comb begin
    state_d     = state_q;
    done_mask_d = done_mask_q;
    fail_mask_d = fail_mask_q;
    code_d      = code_q;
`ifdef EXIT_MON_CYCLE_STAMP_EN
    stamp_d     = stamp_q;
`endif
    if (start_i) begin
      state_d     = ST_RUN;
      done_mask_d = '0;
      fail_mask_d = '0;
      for (int i = 0; i < N_CH; i++) begin
        code_d[i] = '0;
`ifdef EXIT_MON_CYCLE_STAMP_EN
        stamp_d[i] = '0;
`endif
      end
    end else if (run) begin
      // Out-of-range channels match no slot and are silently dropped; first code wins.
      for (int i = 0; i < N_CH; i++) begin
        if (wr_fire && (wr_ch_i == CH_W'(i)) && !done_mask_q[i]) begin
          done_mask_d[i] = 1'b1;
          fail_mask_d[i] = (wr_code_i == CODE_W'(EXIT_SUCCESS)) ? 1'b0 : 1'(EXIT_FAIL);
          code_d[i]      = wr_code_i;
`ifdef EXIT_MON_CYCLE_STAMP_EN
          stamp_d[i]     = cnt;
`endif
        end
      end
      if (&done_mask_d) begin
        state_d = ST_DONE;
      end else if (expire) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      done_mask_q <= '0;
      fail_mask_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        code_q[i] <= '0;
`ifdef EXIT_MON_CYCLE_STAMP_EN
        stamp_q[i] <= '0;
`endif
      end
    end else begin
      state_q     <= state_d;
      done_mask_q <= done_mask_d;
      fail_mask_q <= fail_mask_d;
      code_q      <= code_d;
`ifdef EXIT_MON_CYCLE_STAMP_EN
      stamp_q     <= stamp_d;
`endif
    end
  end

  always_comb begin
    rd_code_o = '0;
`ifdef EXIT_MON_CYCLE_STAMP_EN
    rd_stamp_o = '0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch_i == CH_W'(i)) begin
        rd_code_o = code_q[i];
`ifdef EXIT_MON_CYCLE_STAMP_EN
        rd_stamp_o = stamp_q[i];
`endif
      end
    end
  end

  assign wr_ready_o  = run;
  assign done_o      = (state_q == ST_DONE);
  assign timeout_o   = (state_q == ST_TIMEOUT);
  assign pass_o      = done_o && (fail_mask_q == '0);
  assign done_mask_o = done_mask_q;
  assign fail_mask_o = fail_mask_q;

endmodule
